// File: rtl/vector_regfile.sv
// Vector register file with a lane-masked ALU write port, a load-return port and a load scoreboard.
// Latency: reads are combinational with write-through bypass, so a write is visible in the same cycle.
// Backpressure: never stalls; a load issue is refused (ld_issue_ready=0) while its register is reserved.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   ra1/rd1, ra2/rd2         read ports; rd2 returns register 0 (the scalar register) when sflag=1
//   sflag                    scalar flag; with we it turns the ALU write into a single-element write of reg 0
//   we/wa/wd/wmask           ALU write port with per-lane enables
//   ld_issue/_ra/_ready      load issue handshake that reserves a destination register
//   ld_we/ld_wa/ld_wd        load return port; writes every lane and releases the reservation
//   hazard1/hazard2          read address currently reserved by an outstanding load
//   busy                     scoreboard, one bit per register
module vector_regfile #(
  parameter int LANES = 6,
  parameter int EW    = 8,
  parameter int NREG  = 10,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic [LANES*EW-1:0]   rd1,
  output logic [LANES*EW-1:0]   rd2,
  input  logic                  sflag,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [LANES*EW-1:0]   wd,
  input  logic [LANES-1:0]      wmask,
  input  logic                  ld_issue,
  input  logic [AW-1:0]         ld_issue_ra,
  output logic                  ld_issue_ready,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_wa,
  input  logic [LANES*EW-1:0]   ld_wd,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [NREG-1:0]       busy
);

  localparam int DW = LANES * EW;

  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW-1:0]   ra2_eff;

  // Next-state array. Reads are taken from mem_d, which is what gives the
  // zero-latency write-through: the post-edge value per lane, with wmask and
  // load-over-ALU priority already applied. Writes are masked while in reset
  // so the outputs read as zero for the whole reset window.
  always_comb begin : next_state
    for (int r = 0; r < NREG; r++) begin
      mem_d[r] = mem_q[r];
    end
    busy_d = busy_q;
    if (rst_n) begin
      // Scalar write: wa picks the lane of register 0; out-of-range lanes never match.
      if (we && sflag) begin
        for (int l = 0; l < LANES; l++) begin
          if (wa == AW'(l)) begin
            mem_d[0][l*EW +: EW] = wd[EW-1:0];
          end
        end
      end
      // Vector write; wa >= NREG never matches and is dropped.
      if (we && !sflag) begin
        for (int r = 0; r < NREG; r++) begin
          if (wa == AW'(r)) begin
            for (int l = 0; l < LANES; l++) begin
              if (wmask[l]) begin
                mem_d[r][l*EW +: EW] = wd[l*EW +: EW];
              end
            end
          end
        end
      end
      // Load return is applied after the ALU write so it overrides every lane.
      for (int r = 0; r < NREG; r++) begin
        if (ld_we && (ld_wa == AW'(r))) begin
          mem_d[r]  = ld_wd;
          busy_d[r] = 1'b0;
        end
      end
      // A new reservation is applied last so it survives a same-cycle return.
      for (int r = 0; r < NREG; r++) begin
        if (ld_issue && ld_issue_ready && (ld_issue_ra == AW'(r))) begin
          busy_d[r] = 1'b1;
        end
      end
    end
  end

  assign ra2_eff = sflag ? '0 : ra2;

  // Read muxes; hazards and ready look at the pre-edge scoreboard only.
  always_comb begin : read_ports
    rd1            = '0;
    rd2            = '0;
    hazard1        = 1'b0;
    hazard2        = 1'b0;
    ld_issue_ready = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (ra1 == AW'(r)) begin
        rd1     = mem_d[r];
        hazard1 = busy_q[r];
      end
      if (ra2_eff == AW'(r)) begin
        rd2     = mem_d[r];
        hazard2 = busy_q[r];
      end
      if (ld_issue_ra == AW'(r)) begin
        ld_issue_ready = !busy_q[r];
      end
    end
  end

  assign busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_vector_regfile.sv
// Directed table-driven bench for vector_regfile plus hand-written reset sequences.
// Inputs change on the falling edge; combinational outputs are sampled 1ns later,
// the scoreboard 1ns after the rising edge.
module tb_vector_regfile;

  localparam int LANES = 6;
  localparam int EW    = 8;
  localparam int NREG  = 10;
  localparam int AW    = 4;
  localparam int DW    = LANES * EW;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   ra1, ra2, wa, ld_issue_ra, ld_wa;
  logic [DW-1:0]   rd1, rd2, wd, ld_wd;
  logic            sflag, we, ld_issue, ld_issue_ready, ld_we, hazard1, hazard2;
  logic [LANES-1:0] wmask;
  logic [NREG-1:0] busy;

  int checks   = 0;
  int failures = 0;

  vector_regfile #(.LANES(LANES), .EW(EW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .sflag(sflag), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
    .ld_issue(ld_issue), .ld_issue_ra(ld_issue_ra), .ld_issue_ready(ld_issue_ready),
    .ld_we(ld_we), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic             sflag;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [LANES-1:0] wmask;
    logic             iss;
    logic [AW-1:0]    iss_ra;
    logic             ldwe;
    logic [AW-1:0]    ldwa;
    logic [DW-1:0]    ldwd;
    logic [DW-1:0]    x_rd1;
    logic [DW-1:0]    x_rd2;
    logic             x_h1;
    logic             x_h2;
    logic             x_rdy;
    logic [NREG-1:0]  x_busy;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ra1 = v.ra1; ra2 = v.ra2; sflag = v.sflag;
    we = v.we; wa = v.wa; wd = v.wd; wmask = v.wmask;
    ld_issue = v.iss; ld_issue_ra = v.iss_ra;
    ld_we = v.ldwe; ld_wa = v.ldwa; ld_wd = v.ldwd;
  endtask

  task automatic idle();
    sflag = 0; we = 0; wa = '0; wd = '0; wmask = '0;
    ld_issue = 0; ld_issue_ra = '0; ld_we = 0; ld_wa = '0; ld_wd = '0;
  endtask

  //                 ra1 ra2 sf we wa  wd                 wmask     iss ira ldwe lwa ldwd               rd1                rd2                h1 h2 rdy busy-after
  initial begin
    vec[0]  = '{4'd3, 4'd9, 0, 0, 4'd0,  48'h0,             6'b000000, 0, 4'd0,  0, 4'd0,  48'h0,             48'h0,             48'h0,             0, 0, 1, 10'h000};
    // masked vector write with same-cycle bypass, then held value
    vec[1]  = '{4'd4, 4'd4, 0, 1, 4'd4,  48'h201008040201,  6'b001111, 0, 4'd0,  0, 4'd0,  48'h0,             48'h000008040201,  48'h000008040201,  0, 0, 1, 10'h000};
    vec[2]  = '{4'd4, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 0, 4'd0,  0, 4'd0,  48'h0,             48'h000008040201,  48'h0,             0, 0, 1, 10'h000};
    // scalar write lane 3 of reg 0; rd2 follows reg 0 regardless of ra2
    vec[3]  = '{4'd0, 4'd9, 1, 1, 4'd3,  48'hFFFFFFFFFF5A,  6'b000000, 0, 4'd0,  0, 4'd0,  48'h0,             48'h00005A000000,  48'h00005A000000,  0, 0, 1, 10'h000};
    // scalar write with lane out of range: no change
    vec[4]  = '{4'd0, 4'd4, 1, 1, 4'd7,  48'h000000000077,  6'b111111, 0, 4'd0,  0, 4'd0,  48'h0,             48'h00005A000000,  48'h00005A000000,  0, 0, 1, 10'h000};
    // vector write to wa >= NREG: no effect
    vec[5]  = '{4'd0, 4'd4, 0, 1, 4'd12, 48'hFFFFFFFFFFFF,  6'b111111, 0, 4'd0,  0, 4'd0,  48'h0,             48'h00005A000000,  48'h000008040201,  0, 0, 1, 10'h000};
    vec[6]  = '{4'd9, 4'd9, 0, 1, 4'd9,  48'h010203040506,  6'b110000, 0, 4'd0,  0, 4'd0,  48'h0,             48'h010200000000,  48'h010200000000,  0, 0, 1, 10'h000};
    // load issue to 5, then refused re-issue with hazards raised
    vec[7]  = '{4'd5, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 1, 4'd5,  0, 4'd0,  48'h0,             48'h0,             48'h00005A000000,  0, 0, 1, 10'h020};
    vec[8]  = '{4'd5, 4'd5, 0, 0, 4'd0,  48'h0,             6'b000000, 1, 4'd5,  0, 4'd0,  48'h0,             48'h0,             48'h0,             1, 1, 0, 10'h020};
    // ALU write to a busy register is performed, busy stays
    vec[9]  = '{4'd5, 4'd0, 0, 1, 4'd5,  48'hEEEEEEEEEEC3,  6'b000001, 0, 4'd0,  0, 4'd0,  48'h0,             48'h0000000000C3,  48'h00005A000000,  1, 0, 1, 10'h020};
    // load return: bypassed data, hazard still from pre-edge busy
    vec[10] = '{4'd5, 4'd5, 0, 0, 4'd0,  48'h0,             6'b000000, 0, 4'd0,  1, 4'd5,  48'h111111111111,  48'h111111111111,  48'h111111111111,  1, 1, 1, 10'h000};
    vec[11] = '{4'd5, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 0, 4'd0,  0, 4'd0,  48'h0,             48'h111111111111,  48'h00005A000000,  0, 0, 1, 10'h000};
    // ALU write, load return and issue on reg 2 in one cycle
    vec[12] = '{4'd2, 4'd2, 0, 1, 4'd2,  48'hAAAAAAAAAAAA,  6'b111111, 1, 4'd2,  1, 4'd2,  48'h555555555555,  48'h555555555555,  48'h555555555555,  0, 0, 1, 10'h004};
    vec[13] = '{4'd2, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 0, 4'd0,  0, 4'd0,  48'h0,             48'h555555555555,  48'h00005A000000,  1, 0, 1, 10'h004};
    // issue to a busy reg receiving its return: refused, busy clears
    vec[14] = '{4'd2, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 1, 4'd2,  1, 4'd2,  48'h333333333333,  48'h333333333333,  48'h00005A000000,  1, 0, 0, 10'h000};
    // out-of-range load return and issue
    vec[15] = '{4'd2, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 1, 4'd12, 1, 4'd12, 48'h999999999999,  48'h333333333333,  48'h00005A000000,  0, 0, 0, 10'h000};
    vec[16] = '{4'd5, 4'd0, 0, 0, 4'd0,  48'h0,             6'b000000, 1, 4'd5,  0, 4'd0,  48'h0,             48'h111111111111,  48'h00005A000000,  0, 0, 1, 10'h020};
  end

  initial begin
    rst_n = 1'b0;
    ra1 = 4'd3; ra2 = 4'd9;
    idle();
    #2;
    chk("reset_rd1", rd1, '0);
    chk("reset_rd2", rd2, '0);
    chk("reset_busy", DW'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    // ready for every address: 1 below NREG, 0 above
    for (int a = 0; a < 16; a++) begin
      ld_issue_ra = AW'(a);
      #1;
      chk($sformatf("ready_a%0d", a), DW'(ld_issue_ready), DW'(a < NREG));
    end
    ld_issue_ra = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d_rd1", i), rd1, vec[i].x_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, vec[i].x_rd2);
      chk($sformatf("v%0d_haz1", i), DW'(hazard1), DW'(vec[i].x_h1));
      chk($sformatf("v%0d_haz2", i), DW'(hazard2), DW'(vec[i].x_h2));
      chk($sformatf("v%0d_ready", i), DW'(ld_issue_ready), DW'(vec[i].x_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), DW'(busy), DW'(vec[i].x_busy));
    end

    // Mid-cycle asynchronous reset while reg 5 holds data and is reserved.
    @(negedge clk);
    idle();
    ra1 = 4'd5; ra2 = 4'd5;
    #1;
    chk("prerst_rd1", rd1, 48'h111111111111);
    chk("prerst_haz1", DW'(hazard1), DW'(1'b1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("asyncrst_rd1", rd1, '0);
    chk("asyncrst_busy", DW'(busy), '0);
    chk("asyncrst_haz1", DW'(hazard1), '0);
    chk("asyncrst_haz2", DW'(hazard2), '0);

    // Late return after reset still lands in the array; write accepted on first edge.
    @(negedge clk);
    rst_n = 1'b1;
    ld_we = 1'b1; ld_wa = 4'd5; ld_wd = 48'h777777777777;
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("lateret_rd1", rd1, 48'h777777777777);
    chk("lateret_busy", DW'(busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_regfile.md
VECTOR_REGFILE -- requirements
Module: vector_regfile

Interface
REQ-001 Parameter LANES, default 6: elements per vector register.
REQ-002 Parameter EW, default 8: element width in bits.
REQ-003 Parameter NREG, default 10: vector register count; register 0 is the scalar register (one scalar per lane).
REQ-004 Parameter AW, default 4: register-address width; requires 2^AW >= NREG and 2^AW >= LANES.
REQ-005 Ports: clk in 1, single clock, rising edge; rst_n in 1, reset, asynchronous, active-low.
REQ-006 ra1, ra2 in AW: read addresses; rd1, rd2 out LANES*EW: read data, lane i at bits [i*EW +: EW].
REQ-007 sflag in 1: scalar-operation flag; also selects scalar-element writes.
REQ-008 we in 1, wa in AW, wd in LANES*EW, wmask in LANES: ALU write port (enable, address, data, per-lane enable).
REQ-009 ld_issue in 1, ld_issue_ra in AW, ld_issue_ready out 1: load-issue handshake reserving a destination register.
REQ-010 ld_we in 1, ld_wa in AW, ld_wd in LANES*EW: load-return write port.
REQ-011 hazard1, hazard2 out 1: read address reserved by an outstanding load.
REQ-012 busy out NREG: scoreboard, one bit per register.

Function
REQ-013 Storage: NREG x LANES x EW flops; no initial-value contents; contents defined only by reset and writes.
REQ-014 rd1 = register ra1, combinational.
REQ-015 rd2 = register 0 when sflag=1, else register ra2, combinational.
REQ-016 Vector ALU write (we=1, sflag=0): at the clk edge, lane i of register wa <= wd lane i for every i with wmask[i]=1; other lanes hold.
REQ-017 Scalar ALU write (we=1, sflag=1): at the clk edge, lane wa of register 0 <= wd lane 0; wmask ignored; no effect if wa >= LANES.
REQ-018 Vector ALU write with wa >= NREG: no effect.
REQ-019 Load return (ld_we=1, sflag ignored): all lanes of register ld_wa <= ld_wd at the clk edge; busy[ld_wa] cleared; no effect if ld_wa >= NREG.
REQ-020 ALU write and load return to the same register in the same cycle: load-return data wins in all lanes; the ALU write is dropped.
REQ-021 Write-through bypass: when a write takes effect at the next edge and targets the register or lane driven on rd1/rd2, the output shows the post-write value combinationally in the same cycle; zero-cycle write-to-read latency.
REQ-022 Bypass applies per lane, honours wmask, and applies REQ-020 priority.
REQ-023 ld_issue_ready = !busy[ld_issue_ra] and ld_issue_ra < NREG, combinational.
REQ-024 Issue handshake: when ld_issue=1 and ld_issue_ready=1, busy[ld_issue_ra] is set at the clk edge; when ready=0 the issue is refused and nothing changes.
REQ-025 Issue and load return to the same register in the same cycle: the return data is written and busy ends the cycle set, because the new reservation wins.
REQ-026 Issue to a register that is receiving a return in the same cycle but is busy: ready is computed from the pre-edge busy bit, so the issue is refused.
REQ-027 hazard1 = busy[ra1]; hazard2 = busy[0] when sflag=1, else busy[ra2]; these use the pre-edge busy values, with no bypass of same-cycle clears.
REQ-028 ALU write to a busy register is performed and does not clear busy.
REQ-029 The block is non-blocking: it never stalls internally; the consumer acts on hazard outputs.

Reset
REQ-030 While rst_n=0, asynchronously: all register contents = 0, busy = 0, and therefore hazard1 = hazard2 = 0.
REQ-031 Deassertion is synchronous to the next rising edge; writes and issues are accepted from the first edge with rst_n=1.
REQ-032 Reset asserted with loads outstanding discards all reservations; later ld_we returns are still written to the array.

Verification
REQ-033 Reset, then ra1=3, ra2=9, sflag=0 -> rd1=rd2=0, busy=0, all ld_issue_ready=1 for addresses < NREG.
REQ-034 we=1, wa=4, wd lanes = 20,10,08,04,02,01 hex (lane5..lane0), wmask=6'b001111, ra1=4 in the same cycle -> rd1 shows 00,00,08,04,02,01 in that cycle; the same value is held after the edge.
REQ-035 sflag=1, we=1, wa=3, wd lane0=0x5A -> register 0 lane 3 = 0x5A after the edge; rd2 = register 0 regardless of ra2; a second write with wa=7 -> no change.
REQ-036 ld_issue ra=5 accepted -> busy[5]=1; next-cycle ld_issue ra=5 -> ready=0; ra1=5 -> hazard1=1; ld_we wa=5 with data of all 0x11 -> reg5 = 0x11 in all lanes, busy[5]=0.
REQ-037 Same cycle: we wa=2 with data 0xAA, ld_we wa=2 with data 0x55, ld_issue ra=2 with busy[2]=0 -> reg2 = 0x55 in all lanes, rd of 2 shows 0x55 pre-edge, busy[2]=1 after the edge.
REQ-038 rst_n pulsed low mid-cycle with busy[5]=1 and reg5 nonzero -> immediately reg5 = 0 and busy = 0, without waiting for a clock edge.
